ram_burst_master: RTL

//   Initiator for the single-port synchronous RAM (1-cycle registered read, write on write_en).

---
 rtl/ram_burst_master_if.sv | 37 +++
 rtl/ram_burst_master.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/ram_burst_master_if.sv
// Host-side port bundle of the RAM burst master: command, write-data stream,
// read-data stream and status.
interface ram_burst_master_if #(
  parameter int SIZE  = 16,
  parameter int DEPTH = 256
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [AW-1:0]   cmd_addr;
  logic [LW-1:0]   cmd_len;
  logic [SIZE-1:0] cmd_fill;

  logic            wr_valid;
  logic            wr_ready;
  logic [SIZE-1:0] wr_data;

  logic            rd_valid;
  logic [SIZE-1:0] rd_data;

  logic            busy;
  logic            done;
  logic            err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_fill, wr_valid, wr_data,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_fill, wr_valid, wr_data,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy, done, err
  );
endinterface

// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port synchronous RAM with 1-cycle registered read.
// Executes read, write and fill bursts issued over a valid/ready command port.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// READ   | one read address issued per cycle
// RDRAIN | last read word returned, done pulses with it
// WRITE  | one word written per wr_valid/wr_ready handshake
// FILL   | fill constant written every cycle
// DONE   | one-cycle completion pulse for fill/write/zero-length bursts
module ram_burst_master #(
  parameter  int SIZE  = 16,
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_burst_master_if.slave     host,
  output logic [AW-1:0]         ram_address,
  input  logic [SIZE-1:0]       ram_read_data,
  output logic [SIZE-1:0]       ram_write_data,
  output logic                  ram_write_en
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_RDRAIN,
    S_WRITE,
    S_FILL,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic [SIZE-1:0] fill_q, fill_d;
  logic            err_q, err_d;
  logic            rd_valid_q;
  logic            write_en;
  logic [SIZE-1:0] write_data;

  function automatic logic [AW-1:0] addr_step(input logic [AW-1:0] a);
    return (a == AW'(DEPTH - 1)) ? '0 : a + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      fill_q     <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      fill_q     <= fill_d;
      err_q      <= err_d;
      // RAM read data arrives one cycle after the address is issued
      rd_valid_q <= (state_q == S_READ);
    end
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    cnt_d          = cnt_q;
    fill_d         = fill_q;
    err_d          = 1'b0;
    host.cmd_ready = 1'b0;
    host.wr_ready  = 1'b0;
    host.done      = 1'b0;
    write_en       = 1'b0;
    write_data     = '0;

    case (state_q)
      S_IDLE: begin
        host.cmd_ready = 1'b1;
        if (host.cmd_valid) begin
          addr_d = host.cmd_addr;
          cnt_d  = host.cmd_len;
          fill_d = host.cmd_fill;
          if (host.cmd_op == 2'b11) begin
            err_d = 1'b1;
          end else if (host.cmd_len == '0) begin
            state_d = S_DONE;
          end else begin
            case (host.cmd_op)
              2'b00:   state_d = S_READ;
              2'b01:   state_d = S_WRITE;
              default: state_d = S_FILL;
            endcase
          end
        end
      end

      S_READ: begin
        addr_d = addr_step(addr_q);
        cnt_d  = cnt_q - LW'(1);
        if (cnt_q == LW'(1)) begin
          state_d = S_RDRAIN;
        end
      end

      S_RDRAIN: begin
        host.done = 1'b1;
        state_d   = S_IDLE;
      end

      S_WRITE: begin
        host.wr_ready = 1'b1;
        write_en      = host.wr_valid;
        write_data    = host.wr_data;
        if (host.wr_valid) begin
          addr_d = addr_step(addr_q);
          cnt_d  = cnt_q - LW'(1);
          if (cnt_q == LW'(1)) begin
            state_d = S_DONE;
          end
        end
      end

      S_FILL: begin
        write_en   = 1'b1;
        write_data = fill_q;
        addr_d     = addr_step(addr_q);
        cnt_d      = cnt_q - LW'(1);
        if (cnt_q == LW'(1)) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        host.done = 1'b1;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Gating with rst_n keeps the RAM untouched in the cycle a burst is aborted
  assign ram_write_en   = write_en & rst_n;
  assign ram_write_data = write_data;
  assign ram_address    = addr_q;

  assign host.rd_valid  = rd_valid_q;
  assign host.rd_data   = ram_read_data;
  assign host.busy      = (state_q != S_IDLE);
  assign host.err       = err_q;

endmodule
